// File: rtl/barcode_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | barcode_rx : optical barcode decoder, 8-bit self-clocked station IDs       |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
module barcode_rx #(
    parameter int CNT_W      = 22,
    parameter int MIN_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_FALL = 2'd2,
        SAMPLE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_min_period = CNT_W'(MIN_PERIOD);

    logic             bc_s1_q, bc_s2_q, bc_prev_q;
    logic             w_fall, w_rise;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             accept_pend_q, accept_pend_d;
    logic [7:0]       id_q, id_d;
    logic             id_vld_q, id_vld_d;

    assign w_fall    = bc_prev_q & ~bc_s2_q;
    assign w_rise    = ~bc_prev_q & bc_s2_q;
    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_one;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        accept_pend_d = 1'b0;
        id_d          = id_q;
        id_vld_d      = id_vld_q;

        case (state_q)
            IDLE: begin
                if (w_fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (w_rise) begin
                    if (cnt_q >= c_min_period) begin
                        period_d = cnt_q;
                        state_d  = WAIT_FALL;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == c_cnt_max) begin
                    state_d = IDLE;
                end else if (!bc_s2_q) begin
                    cnt_d = w_cnt_inc;
                end
            end
            WAIT_FALL: begin
                if (w_fall) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else if (cnt_q == c_cnt_max) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            SAMPLE: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == period_q) begin
                    shreg_d   = {shreg_q[6:0], bc_s2_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        accept_pend_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = WAIT_FALL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame completing in the same cycle as the acknowledge takes priority.
        if (clr_ID_vld) begin
            id_vld_d = 1'b0;
        end
        if (accept_pend_q && (shreg_q[7:6] == 2'b00)) begin
            id_d     = shreg_q;
            id_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bc_s1_q       <= 1'b1;
            bc_s2_q       <= 1'b1;
            bc_prev_q     <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            accept_pend_q <= 1'b0;
            id_q          <= '0;
            id_vld_q      <= 1'b0;
        end else begin
            bc_s1_q       <= BC;
            bc_s2_q       <= bc_s1_q;
            bc_prev_q     <= bc_s2_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            accept_pend_q <= accept_pend_d;
            id_q          <= id_d;
            id_vld_q      <= id_vld_d;
        end
    end

    assign ID     = id_q;
    assign ID_vld = id_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_barcode_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_barcode_rx : directed, table-driven bench for barcode_rx               |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module tb_barcode_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bc;
    logic       clr;
    logic [7:0] id;
    logic       id_vld;

    int total = 0;
    int bad   = 0;

    bit         wave[$];
    logic [7:0] m_id;
    logic       m_vld;

    typedef struct {
        logic [7:0] val;
        int         sl;
        int         zl;
        int         ol;
        int         gl;
        bit         clr_before;
        bit         clr_acc;
        logic [7:0] exp_id;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[8];

    barcode_rx #(
        .CNT_W      (22),
        .MIN_PERIOD (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (bc),
        .clr_ID_vld (clr),
        .ID         (id),
        .ID_vld     (id_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {vld,id}=%03h want %03h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input logic [1:0] exp);
        logic [1:0] s;
        s = dut.state_q;
        total++;
        if (s !== exp) begin
            bad++;
            $display("FAIL %s: got state=%0d want %0d", nm, s, exp);
        end
    endtask

    // Returns the wave index of the falling edge that opens the last bit.
    function automatic int build(input logic [7:0] val, input int nbits,
                                 input int sl, input int zl, input int ol, input int gl);
        int f;
        f = 0;
        wave.delete();
        repeat (5) wave.push_back(1'b1);
        repeat (sl) wave.push_back(1'b0);
        repeat (gl) wave.push_back(1'b1);
        for (int b = 0; b < nbits; b++) begin
            if (b == nbits - 1) f = wave.size();
            repeat (val[7-b] ? ol : zl) wave.push_back(1'b0);
            repeat (gl) wave.push_back(1'b1);
        end
        repeat (20) wave.push_back(1'b1);
        return f;
    endfunction

    // Accept lands on the edge sl+4 after the last bit's fall is driven.
    task automatic apply(input int f, input int sl, input bit clr_acc,
                         input logic [8:0] pre, input logic [8:0] post, input string nm);
        for (int i = 0; i < wave.size(); i++) begin
            bc = wave[i];
            tick();
            if (f >= 0 && i == f + sl + 2) begin
                check({nm, " pre-accept"}, {id_vld, id}, pre);
                if (clr_acc) clr = 1'b1;
            end else if (f >= 0 && i == f + sl + 3) begin
                clr = 1'b0;
                check({nm, " accept"}, {id_vld, id}, post);
            end
        end
        if (f >= 0) check({nm, " end"}, {id_vld, id}, post);
    endtask

    task automatic pulse_clr(input string nm);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_vld = 1'b0;
        check(nm, {id_vld, id}, {1'b0, m_id});
    endtask

    initial begin
        int f;

        vecs[0] = '{8'h2A, 1000, 1500, 500, 1000, 1'b0, 1'b0, 8'h2A, 1'b1};
        vecs[1] = '{8'hC5,  100,  150,  50,  100, 1'b1, 1'b0, 8'h2A, 1'b0};
        vecs[2] = '{8'h2A,  100,  150,  50,  100, 1'b0, 1'b0, 8'h2A, 1'b1};
        vecs[3] = '{8'h15,  100,  150,  50,  100, 1'b0, 1'b0, 8'h15, 1'b1};
        vecs[4] = '{8'h07,  100,  150,  50,  100, 1'b1, 1'b1, 8'h07, 1'b1};
        vecs[5] = '{8'h40,  100,  150,  50,  100, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[6] = '{8'h80,  100,  150,  50,  100, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[7] = '{8'h2D,  100,  101,  97,  100, 1'b0, 1'b0, 8'h2D, 1'b1};

        rst = 1'b1;
        bc  = 1'b1;
        clr = 1'b0;
        repeat (3) tick();
        check("reset outputs", {id_vld, id}, 9'h000);
        check_state("reset state", 2'd0);
        rst = 1'b0;
        tick();
        m_id  = 8'h00;
        m_vld = 1'b0;

        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d_%02h", v, vecs[v].val);
            if (vecs[v].clr_before) pulse_clr({nm, " clr"});
            f = build(vecs[v].val, 8, vecs[v].sl, vecs[v].zl, vecs[v].ol, vecs[v].gl);
            apply(f, vecs[v].sl, vecs[v].clr_acc, {m_vld, m_id},
                  {vecs[v].exp_vld, vecs[v].exp_id}, nm);
            m_id  = vecs[v].exp_id;
            m_vld = vecs[v].exp_vld;
        end

        // Two-clock glitch must not start a frame.
        wave.delete();
        repeat (5) wave.push_back(1'b1);
        repeat (2) wave.push_back(1'b0);
        repeat (30) wave.push_back(1'b1);
        apply(-1, 0, 1'b0, 9'h000, 9'h000, "glitch");
        check_state("glitch state", 2'd0);
        check("glitch outputs", {id_vld, id}, {m_vld, m_id});

        f = build(8'h3F, 8, 100, 150, 50, 100);
        apply(f, 100, 1'b0, {m_vld, m_id}, {1'b1, 8'h3F}, "after_glitch_3F");
        m_id  = 8'h3F;
        m_vld = 1'b1;

        // Reset in the middle of a frame, then a clean frame.
        f = build(8'hA5, 4, 100, 150, 50, 100);
        apply(-1, 0, 1'b0, 9'h000, 9'h000, "partial");
        check_state("mid-frame state", 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-frame reset outputs", {id_vld, id}, 9'h000);
        check_state("mid-frame reset state", 2'd0);
        m_id  = 8'h00;
        m_vld = 1'b0;

        f = build(8'h01, 8, 100, 150, 50, 100);
        apply(f, 100, 1'b0, {m_vld, m_id}, {1'b1, 8'h01}, "post_reset_01");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
